// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: owns the PC, pulls opcode/operand bytes over req/ack and
// presents a complete instruction to the decoder with valid/ready.
module instruction_fetch_unit #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic              i_mem_ack,
  input  logic [7:0]        i_mem_data,
  output logic              o_ir_wr,
  output logic [7:0]        o_ir_data,
  output logic [15:0]       o_operand,
  output logic [1:0]        o_instr_len,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_jump_en,
  input  logic [ADDR_W-1:0] i_jump_addr,
  output logic [ADDR_W-1:0] o_pc
);

  typedef enum logic [1:0] {F_OP, F_LO, F_HI, HOLD} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_rd;
  logic              r_ir_wr;
  logic [7:0]        r_ir_data;
  logic [15:0]       r_operand;
  logic [1:0]        r_instr_len;
  logic              r_instr_valid;
  logic              w_take;
  logic [1:0]        w_len;

  // An ack only counts while a request is actually outstanding.
  assign w_take = r_mem_rd & i_mem_ack;

  always_comb begin
    w_len  = 2'd3;
    w_next = r_state;
    case (i_mem_data[7:6])
      2'b00:   w_len = 2'd1;
      2'b01:   w_len = 2'd2;
      default: w_len = 2'd3;
    endcase
    if (i_jump_en) begin
      w_next = F_OP;
    end else begin
      case (r_state)
        F_OP:    if (w_take) w_next = (w_len == 2'd1) ? HOLD : F_LO;
        F_LO:    if (w_take) w_next = (r_instr_len == 2'd2) ? HOLD : F_HI;
        F_HI:    if (w_take) w_next = HOLD;
        HOLD:    if (i_instr_ready) w_next = F_OP;
        default: w_next = F_OP;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= F_OP;
      r_pc          <= RESET_VECTOR;
      r_mem_rd      <= 1'b0;
      r_ir_wr       <= 1'b0;
      r_ir_data     <= 8'h00;
      r_operand     <= 16'h0000;
      r_instr_len   <= 2'd0;
      r_instr_valid <= 1'b0;
    end else if (i_clk_en) begin
      r_state  <= w_next;
      r_mem_rd <= (w_next != HOLD);
      r_ir_wr  <= 1'b0;
      if (i_jump_en) begin
        r_pc          <= i_jump_addr;
        r_instr_valid <= 1'b0;
      end else begin
        if (w_take) r_pc <= r_pc + 1'b1;
        case (r_state)
          F_OP: if (w_take) begin
            r_ir_data   <= i_mem_data;
            r_instr_len <= w_len;
            r_operand   <= 16'h0000;
            r_ir_wr     <= 1'b1;
          end
          F_LO:    if (w_take) r_operand[7:0]  <= i_mem_data;
          F_HI:    if (w_take) r_operand[15:8] <= i_mem_data;
          HOLD:    if (i_instr_ready) r_instr_valid <= 1'b0;
          default: ;
        endcase
        if (w_next == HOLD && r_state != HOLD) r_instr_valid <= 1'b1;
      end
    end
  end

  // The strobe is tied to the enable so the IR never sees it on a stalled cycle.
  assign o_ir_wr       = r_ir_wr & i_clk_en;
  assign o_mem_addr    = r_pc;
  assign o_mem_rd      = r_mem_rd;
  assign o_pc          = r_pc;
  assign o_ir_data     = r_ir_data;
  assign o_operand     = r_operand;
  assign o_instr_len   = r_instr_len;
  assign o_instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: byte memory model, manual ack,
// hand-computed expectations at each step.
module tb_instruction_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst, i_clk_en, i_mem_ack, i_instr_ready, i_jump_en;
  logic [15:0] i_jump_addr;
  logic [7:0]  i_mem_data;
  logic [15:0] o_mem_addr, o_operand, o_pc;
  logic        o_mem_rd, o_ir_wr, o_instr_valid;
  logic [7:0]  o_ir_data;
  logic [1:0]  o_instr_len;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;

  always #5 i_clk = ~i_clk;

  assign i_mem_data = mem[o_mem_addr];

  instruction_fetch_unit #(.ADDR_W(16), .RESET_VECTOR(16'h0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .i_mem_ack(i_mem_ack),
    .i_mem_data(i_mem_data), .o_ir_wr(o_ir_wr), .o_ir_data(o_ir_data),
    .o_operand(o_operand), .o_instr_len(o_instr_len),
    .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .i_jump_en(i_jump_en), .i_jump_addr(i_jump_addr), .o_pc(o_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mem_rd"}, {31'd0, o_mem_rd}, 0);
    chk({tag, ".pc"}, {16'd0, o_pc}, 0);
    chk({tag, ".valid"}, {31'd0, o_instr_valid}, 0);
    chk({tag, ".ir_wr"}, {31'd0, o_ir_wr}, 0);
    chk({tag, ".ir_data"}, {24'd0, o_ir_data}, 0);
    chk({tag, ".operand"}, {16'd0, o_operand}, 0);
    chk({tag, ".len"}, {30'd0, o_instr_len}, 0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h05;
    mem[16'h0010] = 8'h80; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    mem[16'h0013] = 8'h41; mem[16'h0014] = 8'h77;
    mem[16'hFFFF] = 8'h40;

    i_rst = 1'b1; i_clk_en = 1'b1; i_mem_ack = 1'b0; i_instr_ready = 1'b0;
    i_jump_en = 1'b0; i_jump_addr = 16'h0000;
    step(); step();
    chk_reset("rst");

    // Out of reset: request at the reset vector.
    i_rst = 1'b0;
    step();
    chk("boot.mem_rd", {31'd0, o_mem_rd}, 1);
    chk("boot.addr", {16'd0, o_mem_addr}, 16'h0000);
    chk("boot.valid", {31'd0, o_instr_valid}, 0);

    // 1-byte opcode with immediate ack.
    i_mem_ack = 1'b1;
    step();
    i_mem_ack = 1'b0;
    chk("op1.ir_wr", {31'd0, o_ir_wr}, 1);
    chk("op1.ir_data", {24'd0, o_ir_data}, 8'h05);
    chk("op1.len", {30'd0, o_instr_len}, 1);
    chk("op1.valid", {31'd0, o_instr_valid}, 1);
    chk("op1.pc", {16'd0, o_pc}, 16'h0001);
    chk("op1.mem_rd", {31'd0, o_mem_rd}, 0);
    step();
    chk("op1.ir_wr_once", {31'd0, o_ir_wr}, 0);
    chk("op1.valid_held", {31'd0, o_instr_valid}, 1);

    // Jump out of HOLD to the 3-byte instruction.
    i_jump_en = 1'b1; i_jump_addr = 16'h0010;
    step();
    i_jump_en = 1'b0;
    chk("jmp.pc", {16'd0, o_pc}, 16'h0010);
    chk("jmp.valid", {31'd0, o_instr_valid}, 0);
    chk("jmp.mem_rd", {31'd0, o_mem_rd}, 1);

    i_mem_ack = 1'b1;
    step();
    chk("op3.len", {30'd0, o_instr_len}, 3);
    chk("op3.ir_data", {24'd0, o_ir_data}, 8'h80);
    chk("op3.rd_b2b", {31'd0, o_mem_rd}, 1);
    step();
    chk("op3.pc_lo", {16'd0, o_pc}, 16'h0012);
    chk("op3.valid_early", {31'd0, o_instr_valid}, 0);
    step();
    i_mem_ack = 1'b0;
    chk("op3.operand", {16'd0, o_operand}, 16'h1234);
    chk("op3.pc", {16'd0, o_pc}, 16'h0013);
    chk("op3.valid", {31'd0, o_instr_valid}, 1);
    step(); step();
    chk("op3.hold_valid", {31'd0, o_instr_valid}, 1);
    chk("op3.hold_rd", {31'd0, o_mem_rd}, 0);
    chk("op3.hold_operand", {16'd0, o_operand}, 16'h1234);
    i_instr_ready = 1'b1;
    step();
    i_instr_ready = 1'b0;
    chk("op3.accept_valid", {31'd0, o_instr_valid}, 0);
    chk("op3.accept_rd", {31'd0, o_mem_rd}, 1);

    // Three wait cycles before the ack.
    for (int w = 0; w < 3; w++) begin
      step();
      chk("wait.addr", {16'd0, o_mem_addr}, 16'h0013);
      chk("wait.rd", {31'd0, o_mem_rd}, 1);
    end
    i_mem_ack = 1'b1;
    step();
    chk("wait.pc", {16'd0, o_pc}, 16'h0014);
    chk("wait.len", {30'd0, o_instr_len}, 2);

    // Jump during F_LO with a simultaneous ack: byte dropped.
    i_jump_en = 1'b1; i_jump_addr = 16'h0200;
    step();
    i_jump_en = 1'b0; i_mem_ack = 1'b0;
    chk("abort.pc", {16'd0, o_pc}, 16'h0200);
    chk("abort.addr", {16'd0, o_mem_addr}, 16'h0200);
    chk("abort.operand", {16'd0, o_operand}, 16'h0000);
    chk("abort.valid", {31'd0, o_instr_valid}, 0);
    chk("abort.rd", {31'd0, o_mem_rd}, 1);

    // PC wrap: 2-byte instruction at 0xFFFF.
    i_jump_en = 1'b1; i_jump_addr = 16'hFFFF;
    step();
    i_jump_en = 1'b0; i_mem_ack = 1'b1;
    step();
    chk("wrap.addr", {16'd0, o_mem_addr}, 16'h0000);
    step();
    i_mem_ack = 1'b0;
    chk("wrap.operand", {16'd0, o_operand}, 16'h0005);
    chk("wrap.pc", {16'd0, o_pc}, 16'h0001);
    chk("wrap.valid", {31'd0, o_instr_valid}, 1);
    i_instr_ready = 1'b1;
    step();
    i_instr_ready = 1'b0;

    // Clock enable low with ack held: nothing moves.
    i_clk_en = 1'b0; i_mem_ack = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("stall.pc", {16'd0, o_pc}, 16'h0001);
      chk("stall.ir_wr", {31'd0, o_ir_wr}, 0);
      chk("stall.valid", {31'd0, o_instr_valid}, 0);
    end
    i_clk_en = 1'b1;
    step();
    i_mem_ack = 1'b0;
    chk("resume.ir_wr", {31'd0, o_ir_wr}, 1);
    chk("resume.pc", {16'd0, o_pc}, 16'h0002);
    i_clk_en = 1'b0;
    #1;
    chk("resume.ir_wr_gated", {31'd0, o_ir_wr}, 0);

    // Reset wins over a low clock enable.
    i_rst = 1'b1;
    step();
    chk_reset("rst_noen");
    i_rst = 1'b0; i_clk_en = 1'b1;
    step();
    chk("rearm.mem_rd", {31'd0, o_mem_rd}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
